// File: rtl/tl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tl_pkg
// Brief   : Shared lamp codes, sub-phase codes and lamp helper for the
//           N-approach traffic-light controller.
// Revision: 1.0 - initial release
// ============================================================================
package tl_pkg;

    // Lamp codes driven to each approach
    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] LEFT   = 2'b10;
    localparam logic [1:0] RED    = 2'b11;

    // Sub-phase codes (phase index modulo 4)
    localparam logic [1:0] SUB_SG = 2'd0;
    localparam logic [1:0] SUB_SY = 2'd1;
    localparam logic [1:0] SUB_LG = 2'd2;
    localparam logic [1:0] SUB_LY = 2'd3;

    // Lamp shown by the active approach for a given sub-phase
    function automatic logic [1:0] sub_lamp(input logic [1:0] sub);
        logic [1:0] code;
        case (sub)
            SUB_SG:  code = GREEN;
            SUB_SY:  code = YELLOW;
            SUB_LG:  code = LEFT;
            default: code = YELLOW;
        endcase
        return code;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tl_phase_timer.sv
`default_nettype none
// ============================================================================
// Module  : tl_phase_timer
// Brief   : Cycle counter for the current phase with clear, hold and
//           saturate controls.
// Revision: 1.0 - initial release
// ============================================================================
module tl_phase_timer #(
    parameter int TW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          hold,
    input  logic          sat,
    output logic [TW-1:0] count
);

    logic [TW-1:0] r_count;

    // Hold wins over clear so a frozen phase keeps its elapsed time
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (hold) begin
            r_count <= r_count;
        end else if (clr) begin
            r_count <= '0;
        end else if (!sat) begin
            r_count <= r_count + TW'(1);
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/tl_cntr_nphase.sv
`default_nettype none
// ============================================================================
// Module  : tl_cntr_nphase
// Brief   : Round-robin traffic-light controller for N_DIR approaches, each
//           with straight green/yellow and left green/yellow sub-phases.
//           Min/max green, multi-cycle yellow, optional empty-left skip and
//           a freeze input.
// Revision: 1.0 - initial release
// ============================================================================
module tl_cntr_nphase
    import tl_pkg::*;
#(
    parameter int N_DIR      = 2,
    parameter int MIN_GREEN  = 1,
    parameter int MAX_GREEN  = 16,
    parameter int YELLOW_CYC = 1,
    parameter int SKIP_EMPTY = 0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [N_DIR-1:0]             t_str,
    input  logic [N_DIR-1:0]             t_left,
    input  logic                         hold,
    output logic [2*N_DIR-1:0]           lamp,
    output logic [$clog2(4*N_DIR)-1:0]   phase,
    output logic                         phase_chg
);

    localparam int TW  = $clog2(MAX_GREEN + 1);
    localparam int PW  = $clog2(4 * N_DIR);
    localparam int NPH = 4 * N_DIR;
    localparam logic [PW-1:0] C_LAST_PHASE = PW'(NPH - 1);
    localparam logic [PW-1:0] C_LAST_DIR   = PW'(N_DIR - 1);

    // Reject parameter sets the timer or phase logic cannot honour
    if (N_DIR < 1 || MIN_GREEN < 1 || MAX_GREEN < MIN_GREEN ||
        YELLOW_CYC < 1 || YELLOW_CYC > MAX_GREEN + 1 ||
        (SKIP_EMPTY != 0 && SKIP_EMPTY != 1)) begin : g_param_err
        $error("tl_cntr_nphase: illegal parameter combination");
    end

    logic [PW-1:0]    r_phase;
    logic             r_chg;
    logic [TW-1:0]    w_timer;
    logic [1:0]       w_sub;
    logic [PW-1:0]    w_dir;
    logic [N_DIR-1:0] w_sel;
    logic             w_str;
    logic             w_left;
    logic             w_green_ok;
    logic             w_at_max;
    logic             w_yel_done;
    logic             w_sat;
    logic             w_exit;
    logic [PW-1:0]    w_next;

    assign w_sub = r_phase[1:0];
    assign w_dir = r_phase >> 2;

    // One-hot approach select and lamp decode from the registered phase only
    for (genvar d = 0; d < N_DIR; d++) begin : g_dir
        assign w_sel[d] = (w_dir == PW'(d));
        assign lamp[2*d+1:2*d] = w_sel[d] ? sub_lamp(w_sub) : RED;
    end

    assign w_str  = |(t_str & w_sel);
    assign w_left = |(t_left & w_sel);

    assign w_green_ok = (w_timer >= TW'(MIN_GREEN - 1));
    assign w_at_max   = (w_timer == TW'(MAX_GREEN - 1));
    assign w_yel_done = (w_timer == TW'(YELLOW_CYC - 1));
    assign w_sat      = (w_timer == TW'(MAX_GREEN));

    // Exit condition and successor phase for the current sub-phase
    always_comb begin
        w_exit = 1'b0;
        w_next = (r_phase == C_LAST_PHASE) ? '0 : r_phase + PW'(1);
        case (w_sub)
            SUB_SG: w_exit = w_green_ok & (~w_str | w_at_max);
            SUB_LG: w_exit = w_green_ok & (~w_left | w_at_max);
            SUB_SY: begin
                w_exit = w_yel_done;
                if (SKIP_EMPTY != 0 && !w_left) begin
                    w_next = (w_dir == C_LAST_DIR) ? '0 : r_phase + PW'(3);
                end
            end
            default: w_exit = w_yel_done;
        endcase
    end

    tl_phase_timer #(
        .TW (TW)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (w_exit),
        .hold    (hold),
        .sat     (w_sat),
        .count   (w_timer)
    );

    // Phase register and first-cycle strobe; hold freezes both
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase <= '0;
            r_chg   <= 1'b0;
        end else if (hold) begin
            r_chg   <= 1'b0;
        end else begin
            r_chg <= w_exit;
            if (w_exit) begin
                r_phase <= w_next;
            end
        end
    end

    assign phase     = r_phase;
    assign phase_chg = r_chg;

endmodule
`default_nettype wire

// File: tb/tb_tl_cntr_nphase.sv
`default_nettype none
// ============================================================================
// Module  : tb_tl_cntr_nphase
// Brief   : Directed self-checking bench for tl_cntr_nphase using several
//           parameterisations side by side.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tl_cntr_nphase;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic rn, rn3;

    // u0: defaults
    logic [1:0] str0, left0; logic hold0;
    logic [3:0] lamp0; logic [2:0] ph0; logic chg0;
    // u1: MIN 3, MAX 4, YELLOW 3
    logic [1:0] str1, left1; logic hold1;
    logic [3:0] lamp1; logic [2:0] ph1; logic chg1;
    // u2: SKIP_EMPTY
    logic [1:0] str2, left2; logic hold2;
    logic [3:0] lamp2; logic [2:0] ph2; logic chg2;
    // u3: three approaches
    logic [2:0] str3, left3; logic hold3;
    logic [5:0] lamp3; logic [3:0] ph3; logic chg3;

    tl_cntr_nphase u0 (
        .clk(clk), .reset_n(rn), .t_str(str0), .t_left(left0), .hold(hold0),
        .lamp(lamp0), .phase(ph0), .phase_chg(chg0)
    );

    tl_cntr_nphase #(.N_DIR(2), .MIN_GREEN(3), .MAX_GREEN(4), .YELLOW_CYC(3), .SKIP_EMPTY(0)) u1 (
        .clk(clk), .reset_n(rn), .t_str(str1), .t_left(left1), .hold(hold1),
        .lamp(lamp1), .phase(ph1), .phase_chg(chg1)
    );

    tl_cntr_nphase #(.N_DIR(2), .SKIP_EMPTY(1)) u2 (
        .clk(clk), .reset_n(rn), .t_str(str2), .t_left(left2), .hold(hold2),
        .lamp(lamp2), .phase(ph2), .phase_chg(chg2)
    );

    tl_cntr_nphase #(.N_DIR(3)) u3 (
        .clk(clk), .reset_n(rn3), .t_str(str3), .t_left(left3), .hold(hold3),
        .lamp(lamp3), .phase(ph3), .phase_chg(chg3)
    );

    typedef struct {
        logic [1:0] str;
        logic [1:0] left;
        logic       hld;
        int         ph;
        logic [3:0] lmp;
        logic       chg;
    } vec_t;

    vec_t v[13];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int p;

        // Inputs sampled in a cycle decide the state seen after the next edge
        v[0]  = '{2'b01, 2'b00, 1'b0, 0, 4'b1100, 1'b0};
        v[1]  = '{2'b00, 2'b00, 1'b0, 1, 4'b1101, 1'b1};
        v[2]  = '{2'b00, 2'b01, 1'b0, 2, 4'b1110, 1'b1};
        v[3]  = '{2'b00, 2'b01, 1'b0, 2, 4'b1110, 1'b0};
        v[4]  = '{2'b00, 2'b00, 1'b0, 3, 4'b1101, 1'b1};
        v[5]  = '{2'b00, 2'b00, 1'b0, 4, 4'b0011, 1'b1};
        v[6]  = '{2'b10, 2'b00, 1'b0, 4, 4'b0011, 1'b0};
        v[7]  = '{2'b00, 2'b00, 1'b1, 4, 4'b0011, 1'b0};
        v[8]  = '{2'b00, 2'b00, 1'b0, 5, 4'b0111, 1'b1};
        v[9]  = '{2'b00, 2'b00, 1'b1, 5, 4'b0111, 1'b0};
        v[10] = '{2'b00, 2'b10, 1'b0, 6, 4'b1011, 1'b1};
        v[11] = '{2'b00, 2'b00, 1'b0, 7, 4'b0111, 1'b1};
        v[12] = '{2'b00, 2'b00, 1'b0, 0, 4'b1100, 1'b1};

        rn = 1'b0; rn3 = 1'b0;
        str0 = '0; left0 = '0; hold0 = 1'b0;
        str1 = '0; left1 = '0; hold1 = 1'b1;
        str2 = '0; left2 = '0; hold2 = 1'b1;
        str3 = '0; left3 = '0; hold3 = 1'b0;
        repeat (2) @(posedge clk);
        #1 rn = 1'b1;

        // Reset state
        chk("rst_phase", ph0, 0);
        chk("rst_lamp", lamp0, 4'b1100);
        chk("rst_chg", chg0, 0);

        // Default-parameter vector table (legacy 8-state sequence)
        for (int i = 0; i < 13; i++) begin
            str0 = v[i].str; left0 = v[i].left; hold0 = v[i].hld;
            tick;
            chk($sformatf("vec%0d_phase", i), ph0, v[i].ph);
            chk($sformatf("vec%0d_lamp", i), lamp0, v[i].lmp);
            chk($sformatf("vec%0d_chg", i), chg0, v[i].chg);
        end

        // Max green: busy straight sensor forces exit after 4 cycles
        hold1 = 1'b0; str1 = 2'b01;
        for (int k = 1; k <= 3; k++) begin
            tick;
            chk($sformatf("maxg_stay%0d", k), ph1, 0);
        end
        tick;
        chk("maxg_exit_phase", ph1, 1);
        chk("maxg_exit_chg", chg1, 1);
        chk("maxg_exit_lamp", lamp1, 4'b1101);

        // Hold mid-yellow at timer=1, then one more cycle before LG
        str1 = 2'b00;
        tick;
        chk("sy_t1_phase", ph1, 1);
        hold1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick;
            chk($sformatf("hold%0d_phase", k), ph1, 1);
            chk($sformatf("hold%0d_chg", k), chg1, 0);
        end
        hold1 = 1'b0;
        tick;
        chk("rel_phase", ph1, 1);
        tick;
        chk("rel_lg_phase", ph1, 2);
        chk("rel_lg_chg", chg1, 1);
        chk("rel_lg_lamp", lamp1, 4'b1110);

        // Min green with idle sensors: every phase lasts 3 cycles
        for (int j = 0; j < 8; j++) begin
            p = (2 + j) % 8;
            cnt = 0;
            do begin
                tick;
                cnt++;
            end while (!chg1 && cnt < 20);
            chk($sformatf("ming_dur_p%0d", p), cnt, 3);
            chk($sformatf("ming_next_p%0d", p), ph1, (p + 1) % 8);
        end

        // Skip empty left phase
        hold2 = 1'b0;
        tick;
        chk("skip_p1", ph2, 1);
        chk("skip_p1_lamp", lamp2, 4'b1101);
        tick;
        chk("skip_p4", ph2, 4);
        chk("skip_p4_lamp", lamp2, 4'b0011);
        chk("skip_p4_chg", chg2, 1);
        tick;
        chk("skip_p5", ph2, 5);
        tick;
        chk("skip_p0", ph2, 0);
        left2 = 2'b01;
        tick;
        chk("noskip_p1", ph2, 1);
        tick;
        chk("noskip_p2", ph2, 2);
        chk("noskip_lamp", lamp2, 4'b1110);

        // Three approaches: async reset mid-phase, then full wrap
        rn3 = 1'b1;
        repeat (6) tick;
        chk("n3_pre_phase", ph3, 6);
        #2 rn3 = 1'b0;
        #1;
        chk("n3_rst_phase", ph3, 0);
        chk("n3_rst_lamp", lamp3, 6'b111100);
        chk("n3_rst_chg", chg3, 0);
        @(negedge clk);
        rn3 = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick;
            chk($sformatf("n3_seq%0d", k), ph3, k);
        end
        chk("n3_p11_lamp", lamp3, 6'b011111);
        tick;
        chk("n3_wrap_phase", ph3, 0);
        chk("n3_wrap_chg", chg3, 1);
        chk("n3_wrap_lamp", lamp3, 6'b111100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
